glb_reader: RTL and testbench



---
 rtl/glb_reader_if.sv | 12 +
 rtl/glb_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_glb_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_reader_if.sv
// Valid/ready word stream from glb_reader toward the X-bus controller's G2B data input.
interface glb_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/glb_reader.sv
// GLB read initiator: resets the memory macro, then streams (base, length) requests through a skid FIFO.
// Optional abort input is enabled by defining GLB_READER_ABORT_EN.
module glb_reader #(
  parameter int  DATA_WIDTH = 16,
  parameter int  GLB_DEPTH  = 1024,
  parameter int  RD_LATENCY = 2,
  localparam int AW         = $clog2(GLB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  glb_rst,
  input  logic                  glb_rst_busy,
  output logic                  glb_en,
  output logic                  glb_wen,
  output logic [AW-1:0]         glb_addr,
  input  logic [DATA_WIDTH-1:0] glb_data_out,
`ifdef GLB_READER_ABORT_EN
  input  logic                  abort,
`endif
  glb_reader_if.master          m
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(GLB_DEPTH - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_WAIT,
    IDLE,
    RUN,
    DRAIN
`ifdef GLB_READER_ABORT_EN
    , ABORT
`endif
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]         addr_q;
  logic [AW:0]           remaining;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_last;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  done_q;

  logic accept_req;
  logic zero_req;
  logic credit_ok;
  logic flush;
  logic issue;
  logic push;
  logic pop;
  logic last_accept;

`ifdef GLB_READER_ABORT_EN
  logic [1:0] abort_cnt;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    accept_req  = (state == IDLE) && start && (length != '0);
    zero_req    = (state == IDLE) && start && (length == '0);
    credit_ok   = (32'(inflight) + 32'(fifo_count)) < 32'(FIFO_DEPTH);
`ifdef GLB_READER_ABORT_EN
    flush       = abort && ((state == RUN) || (state == DRAIN));
`else
    flush       = 1'b0;
`endif
    issue       = (state == RUN) && credit_ok && !flush;
    push        = pipe_v[RD_LATENCY-1] && !flush;
    pop         = m.valid && m.ready;
    last_accept = pop && m.last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT_RST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      INIT_RST:  state_next = INIT_WAIT;
      INIT_WAIT: if (!glb_rst_busy) state_next = IDLE;
      IDLE:      if (accept_req) state_next = RUN;
      RUN:       if (issue && (remaining == (AW+1)'(1))) state_next = DRAIN;
      DRAIN:     if (last_accept) state_next = IDLE;
`ifdef GLB_READER_ABORT_EN
      ABORT:     if (abort_cnt == 2'(RD_LATENCY - 1)) state_next = IDLE;
`endif
      default:   state_next = INIT_RST;
    endcase
`ifdef GLB_READER_ABORT_EN
    if (flush) state_next = ABORT;
`endif
  end

`ifdef GLB_READER_ABORT_EN
  // Counts the cycles during which stale GLB returns are still arriving after an abort.
  always_ff @(posedge clk) begin
    if (!rst_n || (state != ABORT)) begin
      abort_cnt <= '0;
    end else begin
      abort_cnt <= abort_cnt + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
    end else if (accept_req) begin
      addr_q    <= base_addr;
      remaining <= length;
    end else if (issue) begin
      addr_q    <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // Each stage mirrors one cycle of GLB read latency, carrying the last-word flag alongside.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      pipe_v[0]    <= issue;
      pipe_last[0] <= issue && (remaining == (AW+1)'(1));
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      inflight <= '0;
    end else begin
      unique case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= glb_data_out;
        fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= zero_req || ((state == DRAIN) && last_accept);
    end
  end

  // The issue credit must keep the FIFO from ever being pushed while full.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign glb_rst  = (state == INIT_RST);
  assign glb_en   = issue;
  assign glb_wen  = 1'b0;
  assign glb_addr = addr_q;

  assign m.data   = fifo_data[rd_ptr];
  assign m.valid  = (fifo_count != '0);
  assign m.last   = m.valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_glb_reader.sv
// Scoreboard bench for glb_reader: stimulus queues expected addresses/words, a monitor checks them.
module tb_glb_reader;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          glb_rst;
  logic          glb_rst_busy;
  logic          glb_en;
  logic          glb_wen;
  logic [AW-1:0] glb_addr;
  logic [DW-1:0] glb_data_out;
`ifdef GLB_READER_ABORT_EN
  logic          abort;
`endif

  glb_reader_if #(.DATA_WIDTH(DW)) bus ();

  glb_reader #(
    .DATA_WIDTH (DW),
    .GLB_DEPTH  (DEPTH),
    .RD_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .glb_rst      (glb_rst),
    .glb_rst_busy (glb_rst_busy),
    .glb_en       (glb_en),
    .glb_wen      (glb_wen),
    .glb_addr     (glb_addr),
    .glb_data_out (glb_data_out),
`ifdef GLB_READER_ABORT_EN
    .abort        (abort),
`endif
    .m            (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0]   sb_q [$];
  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] glb_pipe [LAT];

  always #5 clk = ~clk;

  // GLB model: word at address i holds i, delivered LAT cycles after the enable cycle.
  always @(posedge clk) begin
    glb_pipe[0] <= glb_en ? DW'(glb_addr) : DW'(16'hDEAD);
    for (int i = 1; i < LAT; i++) glb_pipe[i] <= glb_pipe[i-1];
  end
  assign glb_data_out = glb_pipe[LAT-1];

  task automatic reportFail(input string name, input logic [31:0] actual, input string required);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got %0h, required %s", name, actual, required);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every issue and every stream handshake is matched against the queued expectations.
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word;
  logic [DW:0] exp_word;
  logic [AW-1:0] exp_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(bus.valid), 32'd1);
        checkOutput("stall_word", 32'({bus.last, bus.data}), 32'(prev_word));
      end
      if (glb_en) begin
        checkOutput("glb_wen", 32'(glb_wen), 32'd0);
        if (addr_q.size() == 0) begin
          reportFail("unexpected_issue", 32'(glb_addr), "no issue");
        end else begin
          exp_addr = addr_q.pop_front();
          checkOutput("issue_addr", 32'(glb_addr), 32'(exp_addr));
        end
      end
      if (bus.valid && bus.ready) begin
        if (sb_q.size() == 0) begin
          reportFail("unexpected_word", 32'({bus.last, bus.data}), "no word");
        end else begin
          exp_word = sb_q.pop_front();
          checkOutput("stream_word", 32'({bus.last, bus.data}), 32'(exp_word));
        end
      end
      prev_stall = bus.valid && !bus.ready;
      prev_word  = {bus.last, bus.data};
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start (cycle 0) and queues the words it should produce; returns in cycle 1.
  task automatic applyStimulus(input int base, input int len);
    int a;
    start     = 1'b1;
    base_addr = AW'(base);
    length    = LW'(len);
    for (int k = 0; k < len; k++) begin
      a = (base + k) % DEPTH;
      addr_q.push_back(AW'(a));
      sb_q.push_back({1'(k == len - 1), DW'(a)});
    end
    nextCycle();
    start = 1'b0;
  endtask

  task automatic runUntilDone(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      nextCycle();
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportFail(name, 32'(busy), "done within cycle budget");
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_words_left"}, 32'(sb_q.size()), 32'd0);
    checkOutput({name, "_issues_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    length       = '0;
    glb_rst_busy = 1'b1;
    bus.ready    = 1'b1;
`ifdef GLB_READER_ABORT_EN
    abort        = 1'b0;
`endif

    // Reset values
    repeat (3) nextCycle();
    #1;
    checkOutput("rst_glb_rst", 32'(glb_rst), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_glb_en", 32'(glb_en), 32'd0);
    checkOutput("rst_glb_wen", 32'(glb_wen), 32'd0);
    checkOutput("rst_glb_addr", 32'(glb_addr), 32'd0);
    checkOutput("rst_m_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_m_last", 32'(bus.last), 32'd0);
    checkOutput("rst_m_data", 32'(bus.data), 32'd0);

    // Release: glb_rst covers exactly the first post-reset cycle
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("release_glb_rst_hi", 32'(glb_rst), 32'd1);
    nextCycle();
    #1;
    checkOutput("release_glb_rst_lo", 32'(glb_rst), 32'd0);
    checkOutput("init_wait_busy", 32'(busy), 32'd1);
    repeat (4) nextCycle();
    glb_rst_busy = 1'b0;
    #1;
    checkOutput("rst_busy_drop_busy", 32'(busy), 32'd1);
    nextCycle();
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // base=10, len=8, m_ready held high
    nextCycle();
    applyStimulus(10, 8);
    #1;
    checkOutput("t2_c1_glb_en", 32'(glb_en), 32'd1);
    checkOutput("t2_c1_addr", 32'(glb_addr), 32'd10);
    checkOutput("t2_c1_busy", 32'(busy), 32'd1);
    for (int c = 2; c <= 13; c++) begin
      nextCycle();
      #1;
      if (c == 3) checkOutput("t2_c3_valid", 32'(bus.valid), 32'd0);
      if (c == 4) begin
        checkOutput("t2_c4_valid", 32'(bus.valid), 32'd1);
        checkOutput("t2_c4_data", 32'(bus.data), 32'd10);
      end
      if (c == 11) begin
        checkOutput("t2_c11_last", 32'(bus.last), 32'd1);
        checkOutput("t2_c11_data", 32'(bus.data), 32'd17);
        checkOutput("t2_c11_done", 32'(done), 32'd0);
      end
      if (c == 12) begin
        checkOutput("t2_c12_done", 32'(done), 32'd1);
        checkOutput("t2_c12_busy", 32'(busy), 32'd0);
        checkOutput("t2_c12_valid", 32'(bus.valid), 32'd0);
      end
      if (c == 13) checkOutput("t2_c13_done", 32'(done), 32'd0);
    end
    checkDrained("t2");

    // Address wrap: 1021, 1022, 1023, 0, 1, 2
    nextCycle();
    applyStimulus(DEPTH - 3, 6);
    runUntilDone("t3_done", 40);
    checkDrained("t3");

    // len=20 with random back-pressure
    nextCycle();
    applyStimulus(100, 20);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        bus.ready = 1'($urandom_range(0, 1));
        #1;
        if (done) seen = 1'b1;
        else nextCycle();
      end
      if (!seen) reportFail("t4_done", 32'(busy), "done within cycle budget");
    end
    bus.ready = 1'b1;
    checkDrained("t4");

    // len=0: done one cycle after start, no issue
    nextCycle();
    applyStimulus(50, 0);
    #1;
    checkOutput("t5_done", 32'(done), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_glb_en", 32'(glb_en), 32'd0);
    nextCycle();
    #1;
    checkOutput("t5_done_pulse", 32'(done), 32'd0);

    // start while busy is ignored
    nextCycle();
    applyStimulus(200, 4);
    nextCycle();
    start     = 1'b1;
    base_addr = AW'(500);
    length    = LW'(3);
    nextCycle();
    start = 1'b0;
    runUntilDone("t6_done", 40);
    repeat (8) nextCycle();
    #1;
    checkOutput("t6_idle_busy", 32'(busy), 32'd0);
    checkDrained("t6");

    // rst_n low mid-transfer
    nextCycle();
    applyStimulus(400, 8);
    repeat (3) nextCycle();
    rst_n        = 1'b0;
    glb_rst_busy = 1'b1;
    sb_q.delete();
    addr_q.delete();
    nextCycle();
    #1;
    checkOutput("t7_glb_rst", 32'(glb_rst), 32'd1);
    checkOutput("t7_valid", 32'(bus.valid), 32'd0);
    checkOutput("t7_busy", 32'(busy), 32'd1);
    checkOutput("t7_glb_en", 32'(glb_en), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    repeat (2) nextCycle();
    glb_rst_busy = 1'b0;
    repeat (2) nextCycle();
    #1;
    checkOutput("t7_reinit_busy", 32'(busy), 32'd0);
    nextCycle();
    applyStimulus(7, 2);
    runUntilDone("t7_done", 20);
    checkDrained("t7");

`ifdef GLB_READER_ABORT_EN
    // Abort at cycle 6 of a len=16 read: issues 300..304, handshakes 300..302
    nextCycle();
    start     = 1'b1;
    base_addr = AW'(300);
    length    = LW'(16);
    for (int k = 0; k < 5; k++) addr_q.push_back(AW'(300 + k));
    for (int k = 0; k < 3; k++) sb_q.push_back({1'b0, DW'(300 + k)});
    nextCycle();
    start = 1'b0;
    repeat (5) nextCycle();
    abort = 1'b1;
    nextCycle();
    abort = 1'b0;
    #1;
    checkOutput("t8_c7_valid", 32'(bus.valid), 32'd0);
    checkOutput("t8_c7_busy", 32'(busy), 32'd1);
    nextCycle();
    #1;
    checkOutput("t8_c8_busy", 32'(busy), 32'd1);
    checkOutput("t8_c8_valid", 32'(bus.valid), 32'd0);
    nextCycle();
    #1;
    checkOutput("t8_c9_busy", 32'(busy), 32'd0);
    checkOutput("t8_c9_done", 32'(done), 32'd0);
    nextCycle();
    #1;
    checkOutput("t8_c10_done", 32'(done), 32'd0);
    checkDrained("t8");
    nextCycle();
    applyStimulus(5, 2);
    runUntilDone("t8_post_done", 20);
    checkDrained("t8_post");
`endif

    repeat (3) nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
